// File: rtl/gpio_serial_loader_pkg.sv
// Shared definitions for the GPIO serial loader: FSM state encoding and default geometry.
package gpio_serial_loader_pkg;

    localparam int GPIO_CFG_WIDTH = 13;
    localparam int DEF_NPADS      = 19;
    localparam int DEF_WORD       = GPIO_CFG_WIDTH;
    localparam int DEF_CLKDIV     = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_SHIFT_LO  = 3'd2,
        ST_SHIFT_HI  = 3'd3,
        ST_LOAD_WAIT = 3'd4,
        ST_LOAD_HI   = 3'd5
    } state_t;

endpackage

// File: rtl/gpio_serial_loader_tick.sv
// Half-period divider for the serial clock: one-cycle tick on the last clk of each half-period.
module gpio_serial_loader_tick #(
    parameter int CLKDIV = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    logic [CW-1:0] div_cnt_reg;

    assign tick = !clear && (div_cnt_reg == CW'(CLKDIV - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt_reg <= '0;
        end else if (clear || tick) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/gpio_serial_loader.sv
// Loads both GPIO config shift chains from the housekeeping register file in one triggered
// transfer, and passes the bit-bang register straight through while idle.
module gpio_serial_loader
    import gpio_serial_loader_pkg::*;
#(
    parameter int NPADS  = DEF_NPADS,
    parameter int WORD   = DEF_WORD,
    parameter int CLKDIV = DEF_CLKDIV
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            xfer_start,
    output logic [4:0]      cfg_addr,
    input  logic [WORD-1:0] cfg_data_1,
    input  logic [WORD-1:0] cfg_data_2,
    input  logic            bb_enable,
    input  logic            bb_resetn,
    input  logic            bb_clock,
    input  logic            bb_load,
    input  logic            bb_data_1,
    input  logic            bb_data_2,
    output logic            busy,
    output logic            done,
    output logic            serial_clock,
    output logic            serial_load,
    output logic            serial_resetn,
    output logic            serial_data_1,
    output logic            serial_data_2
);

    state_t          state_reg, state_next;
    logic [4:0]      pad_cnt_reg, pad_cnt_next;
    logic [3:0]      bit_cnt_reg, bit_cnt_next;
    logic [4:0]      cfg_addr_reg, cfg_addr_next;
    logic [WORD-1:0] shreg_1_reg, shreg_1_next;
    logic [WORD-1:0] shreg_2_reg, shreg_2_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            sclk_reg, sclk_next;
    logic            sload_reg, sload_next;
    logic            sdata_1_reg, sdata_1_next;
    logic            sdata_2_reg, sdata_2_next;
    logic            sresetn_reg;
    logic            tick;
    logic            tick_clear;
    logic            bb_sel;

    // Divider only runs inside timed phases, so every phase starts from a fresh count.
    assign tick_clear = (state_reg == ST_IDLE) || (state_reg == ST_FETCH);

    gpio_serial_loader_tick #(
        .CLKDIV (CLKDIV)
    ) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .clear  (tick_clear),
        .tick   (tick)
    );

    always_comb begin
        state_next    = state_reg;
        pad_cnt_next  = pad_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        cfg_addr_next = cfg_addr_reg;
        shreg_1_next  = shreg_1_reg;
        shreg_2_next  = shreg_2_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        sclk_next     = sclk_reg;
        sload_next    = sload_reg;
        sdata_1_next  = sdata_1_reg;
        sdata_2_next  = sdata_2_reg;
        case (state_reg)
            ST_IDLE: begin
                if (xfer_start && !bb_enable) begin
                    state_next    = ST_FETCH;
                    busy_next     = 1'b1;
                    pad_cnt_next  = 5'(NPADS - 1);
                    cfg_addr_next = 5'(NPADS - 1);
                end
            end
            ST_FETCH: begin
                shreg_1_next = cfg_data_1;
                shreg_2_next = cfg_data_2;
                bit_cnt_next = 4'(WORD - 1);
                sdata_1_next = cfg_data_1[WORD-1];
                sdata_2_next = cfg_data_2[WORD-1];
                sclk_next    = 1'b0;
                state_next   = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                if (tick) begin
                    sclk_next  = 1'b1;
                    state_next = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (tick) begin
                    sclk_next = 1'b0;
                    if (bit_cnt_reg != 4'd0) begin
                        // MSB-first: the next bit is always just below the current MSB.
                        bit_cnt_next = bit_cnt_reg - 4'd1;
                        shreg_1_next = shreg_1_reg << 1;
                        shreg_2_next = shreg_2_reg << 1;
                        sdata_1_next = shreg_1_reg[WORD-2];
                        sdata_2_next = shreg_2_reg[WORD-2];
                        state_next   = ST_SHIFT_LO;
                    end else if (pad_cnt_reg != 5'd0) begin
                        pad_cnt_next  = pad_cnt_reg - 5'd1;
                        cfg_addr_next = pad_cnt_reg - 5'd1;
                        state_next    = ST_FETCH;
                    end else begin
                        sdata_1_next = 1'b0;
                        sdata_2_next = 1'b0;
                        state_next   = ST_LOAD_WAIT;
                    end
                end
            end
            ST_LOAD_WAIT: begin
                if (tick) begin
                    sload_next = 1'b1;
                    state_next = ST_LOAD_HI;
                end
            end
            ST_LOAD_HI: begin
                if (tick) begin
                    sload_next = 1'b0;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            pad_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            cfg_addr_reg <= '0;
            shreg_1_reg  <= '0;
            shreg_2_reg  <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            sclk_reg     <= 1'b0;
            sload_reg    <= 1'b0;
            sdata_1_reg  <= 1'b0;
            sdata_2_reg  <= 1'b0;
            sresetn_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pad_cnt_reg  <= pad_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            cfg_addr_reg <= cfg_addr_next;
            shreg_1_reg  <= shreg_1_next;
            shreg_2_reg  <= shreg_2_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            sclk_reg     <= sclk_next;
            sload_reg    <= sload_next;
            sdata_1_reg  <= sdata_1_next;
            sdata_2_reg  <= sdata_2_next;
            sresetn_reg  <= 1'b1;
        end
    end

    // Only combinational path: bit-bang bits straight to the chains while idle.
    assign bb_sel = (state_reg == ST_IDLE) && bb_enable;

    assign serial_clock  = bb_sel ? bb_clock  : sclk_reg;
    assign serial_load   = bb_sel ? bb_load   : sload_reg;
    assign serial_resetn = bb_sel ? bb_resetn : sresetn_reg;
    assign serial_data_1 = bb_sel ? bb_data_1 : sdata_1_reg;
    assign serial_data_2 = bb_sel ? bb_data_2 : sdata_2_reg;
    assign cfg_addr      = cfg_addr_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Directed bench for gpio_serial_loader: chain shift model, pulse counters and bit-bang mux checks.
module tb_gpio_serial_loader;

    localparam int NPADS = 19;
    localparam int WORD  = 13;
    localparam int NBITS = NPADS * WORD;

    logic            clk = 1'b0;
    logic            resetn;
    logic            xfer_start;
    logic [4:0]      cfg_addr;
    logic [WORD-1:0] cfg_data_1, cfg_data_2;
    logic            bb_enable, bb_resetn, bb_clock, bb_load, bb_data_1, bb_data_2;
    logic            busy, done;
    logic            serial_clock, serial_load, serial_resetn, serial_data_1, serial_data_2;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;

    gpio_serial_loader dut (
        .clk           (clk),
        .resetn        (resetn),
        .xfer_start    (xfer_start),
        .cfg_addr      (cfg_addr),
        .cfg_data_1    (cfg_data_1),
        .cfg_data_2    (cfg_data_2),
        .bb_enable     (bb_enable),
        .bb_resetn     (bb_resetn),
        .bb_clock      (bb_clock),
        .bb_load       (bb_load),
        .bb_data_1     (bb_data_1),
        .bb_data_2     (bb_data_2),
        .busy          (busy),
        .done          (done),
        .serial_clock  (serial_clock),
        .serial_load   (serial_load),
        .serial_resetn (serial_resetn),
        .serial_data_1 (serial_data_1),
        .serial_data_2 (serial_data_2)
    );

    always #5 clk = ~clk;

    // Register-file model: combinational read at cfg_addr.
    always @* begin
        if (mode == 0) begin
            cfg_data_1 = 13'h1809;
            cfg_data_2 = 13'h1809;
        end else begin
            cfg_data_1 = 13'(cfg_addr);
            cfg_data_2 = ~13'(cfg_addr);
        end
    end

    // Chain model and event counters, sampled on the falling edge.
    logic             prev_sclk = 1'b0, prev_load = 1'b0;
    logic [NBITS-1:0] chain_1 = '0, chain_2 = '0, lat_1 = '0, lat_2 = '0;
    int rises = 0, load_cycles = 0, load_pulses = 0, done_cnt = 0, run = 0, done_run = 0;

    always @(negedge clk) begin
        prev_sclk <= serial_clock;
        prev_load <= serial_load;
        if (serial_clock && !prev_sclk) begin
            rises   <= rises + 1;
            chain_1 <= {chain_1[NBITS-2:0], serial_data_1};
            chain_2 <= {chain_2[NBITS-2:0], serial_data_2};
        end
        if (serial_load) load_cycles <= load_cycles + 1;
        if (serial_load && !prev_load) load_pulses <= load_pulses + 1;
        if (!serial_load && prev_load) begin
            lat_1 <= chain_1;
            lat_2 <= chain_2;
        end
        if (busy) run <= run + 1;
        else      run <= 0;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_run <= run;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) xfer_start = 1'b1;
        @(negedge clk) xfer_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string tag);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_words(input string tag, input int m);
        for (int p = 0; p < NPADS; p++) begin
            logic [WORD-1:0] e1, e2;
            e1 = (m == 0) ? 13'h1809 : 13'(p);
            e2 = (m == 0) ? 13'h1809 : ~13'(p);
            check($sformatf("%s_c1_pad%0d", tag, p), 32'(lat_1[WORD*p +: WORD]), 32'(e1));
            check($sformatf("%s_c2_pad%0d", tag, p), 32'(lat_2[WORD*p +: WORD]), 32'(e2));
        end
    endtask

    initial begin
        int r0, lp0, lc0, d0, n;
        logic [4:0] bbv [4];

        resetn = 1'b0; xfer_start = 1'b0;
        bb_enable = 1'b0; bb_resetn = 1'b0; bb_clock = 1'b0; bb_load = 1'b0;
        bb_data_1 = 1'b0; bb_data_2 = 1'b0;

        // 1. reset values, then serial_resetn rises one clk after release
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({busy, done, serial_clock, serial_load, serial_resetn,
                                  serial_data_1, serial_data_2}), 32'd0);
        check("rst_cfg_addr", 32'(cfg_addr), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("rel_serial_resetn", 32'(serial_resetn), 32'd1);
        check("rel_busy", 32'(busy), 32'd0);

        // 2. uniform 0x1809 transfer
        mode = 0;
        r0 = rises; lp0 = load_pulses; lc0 = load_cycles; d0 = done_cnt;
        pulse_start();
        check("t2_busy_rise", 32'(busy), 32'd1);
        check("t2_first_addr", 32'(cfg_addr), 32'd18);
        wait_done(d0, "t2");
        check("t2_rises", 32'(rises - r0), 32'd247);
        check("t2_load_pulses", 32'(load_pulses - lp0), 32'd1);
        check("t2_load_cycles", 32'(load_cycles - lc0), 32'd4);
        check("t2_busy_cycles", 32'(done_run), 32'd2003);
        check("t2_done_count", 32'(done_cnt - d0), 32'd1);
        check_words("t2", 0);

        // 3. distinct chains: chain1 = pad index, chain2 = ~pad index
        mode = 1;
        d0 = done_cnt;
        pulse_start();
        wait_done(d0, "t3");
        check_words("t3", 1);

        // 4. bit-bang passthrough: {resetn, clock, load, data_1, data_2}
        bb_enable = 1'b1;
        bbv[0] = 5'b11010; bbv[1] = 5'b10010; bbv[2] = 5'b01101; bbv[3] = 5'b00000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            {bb_resetn, bb_clock, bb_load, bb_data_1, bb_data_2} = bbv[i];
            #1;
            check($sformatf("t4_mirror%0d", i), 32'({serial_resetn, serial_clock, serial_load,
                                                      serial_data_1, serial_data_2}), 32'(bbv[i]));
        end
        d0 = done_cnt;
        pulse_start();
        repeat (5) @(negedge clk);
        check("t4_busy_ignored", 32'(busy), 32'd0);
        check("t4_no_done", 32'(done_cnt - d0), 32'd0);
        bb_enable = 1'b0;
        {bb_resetn, bb_clock, bb_load, bb_data_1, bb_data_2} = 5'b00000;

        // 5a. xfer_start during busy is ignored
        mode = 0;
        r0 = rises; d0 = done_cnt;
        pulse_start();
        repeat (100) @(negedge clk);
        pulse_start();
        wait_done(d0, "t5a");
        check("t5a_busy_cycles", 32'(done_run), 32'd2003);
        check("t5a_done_count", 32'(done_cnt - d0), 32'd1);
        check("t5a_rises", 32'(rises - r0), 32'd247);

        // 5b. bb_enable raised mid-transfer takes effect only once idle
        r0 = rises; d0 = done_cnt;
        pulse_start();
        repeat (500) @(negedge clk);
        bb_enable = 1'b1;
        {bb_resetn, bb_clock, bb_load, bb_data_1, bb_data_2} = 5'b10110;
        @(negedge clk);
        check("t5b_mid_busy", 32'(busy), 32'd1);
        check("t5b_mid_load", 32'(serial_load), 32'd0);
        wait_done(d0, "t5b");
        check("t5b_busy_cycles", 32'(done_run), 32'd2003);
        check("t5b_rises", 32'(rises - r0), 32'd247);
        check("t5b_follow_bb", 32'({serial_resetn, serial_clock, serial_load,
                                    serial_data_1, serial_data_2}), 32'b10110);
        bb_enable = 1'b0;
        {bb_resetn, bb_clock, bb_load, bb_data_1, bb_data_2} = 5'b00000;
        repeat (2) @(negedge clk);

        // 6. async reset mid-shift at pad 10, then a clean transfer
        d0 = done_cnt;
        pulse_start();
        n = 0;
        while (run < 900 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("t6_at_pad10", 32'(cfg_addr), 32'd10);
        #2 resetn = 1'b0;
        #1;
        check("t6_async_outputs", 32'({busy, done, serial_clock, serial_load, serial_resetn,
                                       serial_data_1, serial_data_2}), 32'd0);
        check("t6_async_cfg_addr", 32'(cfg_addr), 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_no_done", 32'(done_cnt - d0), 32'd0);
        r0 = rises; d0 = done_cnt;
        pulse_start();
        wait_done(d0, "t6");
        check("t6_busy_cycles", 32'(done_run), 32'd2003);
        check("t6_rises", 32'(rises - r0), 32'd247);
        check_words("t6", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
